// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub
//   Pipelined two's-complement adder/subtractor. The WIDTH-bit add is split
//   into STAGES slices of WIDTH/STAGES bits. Each stage adds one slice, and the
//   carry is registered between stages. Throughput is one op per cycle and
//   latency is STAGES cycles. The final stage register is the output register.
//
//   Optional feature: define SATURATE_EN to clamp the result on signed
//   overflow. A positive overflow clamps to the most positive value and a
//   negative overflow clamps to the most negative value. carryOut stays raw.
//
// Ports
//   clk       rising-edge clock
//   resetN    synchronous reset, active-low
//   aIn/bIn   operands (WIDTH)
//   subIn     0: A+B, 1: A-B (A + ~B + 1)
//   inValid   operands valid          inReady  operands accepted this cycle
//   out       result (WIDTH)          carryOut carry out of MSB (sub: 1 = no borrow)
//   overflow  signed overflow         zero     out == 0
//   negative  out[WIDTH-1]            outValid result valid
//   outReady  consumer accepts result
module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  input  logic             subIn,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] out,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             outValid,
  input  logic             outReady
);

  localparam int S       = WIDTH / STAGES;
  localparam int LAST_SH = (STAGES - 1) * S;

  logic             advance;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_reg;
  logic             carry_out_reg;
  logic             overflow_reg;
  logic             zero_reg;
  logic             negative_reg;

  // The whole pipe moves as one unit. It shifts unless a finished result is
  // still waiting for the consumer. Reset is included so that inReady reads 1
  // throughout reset.
  assign advance = !resetN || !out_valid_reg || outReady;
  assign inReady = advance;

  // B is inverted for subtraction. The "+1" enters as the stage-0 carry-in.
  logic [WIDTH-1:0] b_eff;
  assign b_eff = subIn ? ~bIn : bIn;

  // Intermediate stages 0 .. STAGES-2. Each stage carries the full operands
  // forward, so that the upper slices and both MSBs stay aligned with the
  // partial sum.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES - 1; gi = gi + 1) begin : g_stage
      localparam int SH = gi * S;

      logic             v_src;
      logic             c_src;
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] sum_src;
      logic [S:0]       slice_sum;
      logic [WIDTH-1:0] sum_next;

      logic             valid_reg;
      logic             carry_reg;
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;
      logic [WIDTH-1:0] sum_reg;

      if (gi == 0) begin : g_head
        assign v_src   = inValid;
        assign c_src   = subIn;
        assign a_src   = aIn;
        assign b_src   = b_eff;
        assign sum_src = '0;
      end else begin : g_body
        assign v_src   = g_stage[gi-1].valid_reg;
        assign c_src   = g_stage[gi-1].carry_reg;
        assign a_src   = g_stage[gi-1].a_reg;
        assign b_src   = g_stage[gi-1].b_reg;
        assign sum_src = g_stage[gi-1].sum_reg;
      end

      assign slice_sum = {1'b0, S'(a_src >> SH)} + {1'b0, S'(b_src >> SH)} + (S+1)'(c_src);

      always_comb begin
        sum_next = sum_src;
        sum_next[SH +: S] = slice_sum[S-1:0];
      end

      always_ff @(posedge clk) begin
        if (!resetN) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          a_reg     <= '0;
          b_reg     <= '0;
          sum_reg   <= '0;
        end else if (advance) begin
          valid_reg <= v_src;
          carry_reg <= slice_sum[S];
          a_reg     <= a_src;
          b_reg     <= b_src;
          sum_reg   <= sum_next;
        end
      end
    end
  endgenerate

  // Inputs to the final stage. With a single stage, these come straight from
  // the ports.
  logic             f_valid;
  logic             f_carry_in;
  logic [WIDTH-1:0] f_a;
  logic [WIDTH-1:0] f_b;
  logic [WIDTH-1:0] f_sum;

  generate
    if (STAGES == 1) begin : g_single
      assign f_valid    = inValid;
      assign f_carry_in = subIn;
      assign f_a        = aIn;
      assign f_b        = b_eff;
      assign f_sum      = '0;
    end else begin : g_multi
      assign f_valid    = g_stage[STAGES-2].valid_reg;
      assign f_carry_in = g_stage[STAGES-2].carry_reg;
      assign f_a        = g_stage[STAGES-2].a_reg;
      assign f_b        = g_stage[STAGES-2].b_reg;
      assign f_sum      = g_stage[STAGES-2].sum_reg;
    end
  endgenerate

  logic [S:0]       f_slice;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] result;
  logic             ovf;

  assign f_slice = {1'b0, S'(f_a >> LAST_SH)} + {1'b0, S'(f_b >> LAST_SH)} + (S+1)'(f_carry_in);

  always_comb begin
    raw_sum = f_sum;
    raw_sum[LAST_SH +: S] = f_slice[S-1:0];
    // Overflow occurs when both operands have the same sign and the result
    // sign differs from it.
    ovf    = (f_a[WIDTH-1] == f_b[WIDTH-1]) && (raw_sum[WIDTH-1] != f_a[WIDTH-1]);
    result = raw_sum;
`ifdef SATURATE_EN
    if (ovf) begin
      result = f_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      zero_reg      <= 1'b0;
      negative_reg  <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= f_valid;
      out_reg       <= result;
      carry_out_reg <= f_slice[S];
      overflow_reg  <= ovf;
      zero_reg      <= (result == '0);
      negative_reg  <= result[WIDTH-1];
    end
  end

  assign out      = out_reg;
  assign carryOut = carry_out_reg;
  assign overflow = overflow_reg;
  assign zero     = zero_reg;
  assign negative = negative_reg;
  assign outValid = out_valid_reg;

endmodule
